cdc_pulse_mc: RTL and testbench

CDC_PULSE_MC -- requirements
Module: cdc_pulse_mc

---
 rtl/cdc_pulse_pkg.sv | 12 +
 rtl/cdc_pulse_mc_sync_bit.sv | 29 ++
 rtl/cdc_pulse_mc.sv | 115 +++++++++++
 tb/tb_cdc_pulse_mc.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pulse_pkg.sv
// Shared types and constants for the multi-channel pulse synchronizer.
`timescale 1ns/1ps
package cdc_pulse_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_pulse_mc_sync_bit.sv
// Single-bit synchronizer: a flop chain in the destination clock, cleared by async reset.
`timescale 1ns/1ps
module cdc_sync_bit
   import cdc_pulse_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   // Depth never drops below the metastability-safe minimum.
   localparam int DEPTH = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

   logic [DEPTH-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[DEPTH-2:0], d};
      end
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/cdc_pulse_mc.sv
// Multi-channel pulse crossing from clk_a to clk_b using a toggle req/ack handshake
// per channel, with a saturating pending-event counter and sticky overflow flag.
`timescale 1ns/1ps
module cdc_pulse_mc
   import cdc_pulse_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 3
) (
   input  logic             clk_a,
   input  logic             clk_b,
   input  logic             rst_n,
   input  logic [NCH-1:0]   pulse_a,
   input  logic [NCH-1:0]   clr_ovf_a,
   output logic [NCH-1:0]   pulse_b,
   output logic [NCH-1:0]   busy_a,
   output logic [NCH-1:0]   overflow_a
);

   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] pend;
      logic [CNT_W-1:0] pend_nxt;
      logic             req_tgl;
      logic             req_nxt;
      logic             ovf;
      logic             ovf_nxt;
      logic             drop;
      logic             ack_sync;
      logic             req_sync;
      logic             ack_tgl;
      logic             pulse_reg;

      cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
         .clk   (clk_a),
         .rst_n (rst_n),
         .d     (ack_tgl),
         .q     (ack_sync)
      );

      always_ff @(posedge clk_a or negedge rst_n) begin
         if (!rst_n) begin
            state   <= IDLE;
            pend    <= '0;
            req_tgl <= 1'b0;
            ovf     <= 1'b0;
         end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            req_tgl <= req_nxt;
            ovf     <= ovf_nxt;
         end
      end

      // A launch that consumes a pending event while a new one arrives leaves pend unchanged.
      always_comb begin
         state_nxt = state;
         pend_nxt  = pend;
         req_nxt   = req_tgl;
         drop      = 1'b0;
         case (state)
            IDLE: begin
               if (pulse_a[ch] || (pend != '0)) begin
                  req_nxt   = ~req_tgl;
                  state_nxt = WAIT_ACK;
                  if ((pend != '0) && !pulse_a[ch]) begin
                     pend_nxt = pend - 1'b1;
                  end
               end
            end
            WAIT_ACK: begin
               if (ack_sync == req_tgl) begin
                  state_nxt = IDLE;
               end
               if (pulse_a[ch]) begin
                  if (pend != PEND_MAX) begin
                     pend_nxt = pend + 1'b1;
                  end else begin
                     drop = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
         ovf_nxt = (ovf & ~clr_ovf_a[ch]) | drop;
      end

      cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
         .clk   (clk_b),
         .rst_n (rst_n),
         .d     (req_tgl),
         .q     (req_sync)
      );

      // The delayed copy doubles as the acknowledge toggle, so ack leaves with pulse_b.
      always_ff @(posedge clk_b or negedge rst_n) begin
         if (!rst_n) begin
            ack_tgl   <= 1'b0;
            pulse_reg <= 1'b0;
         end else begin
            ack_tgl   <= req_sync;
            pulse_reg <= req_sync ^ ack_tgl;
         end
      end

      assign pulse_b[ch]    = pulse_reg;
      assign busy_a[ch]     = (state == WAIT_ACK) || (pend != '0);
      assign overflow_a[ch] = ovf;
   end

endmodule

// File: tb/tb_cdc_pulse_mc.sv
// Directed self-checking bench for cdc_pulse_mc: latency, pending queue, overflow,
// multi-channel independence and reset discard.
`timescale 1ns/1ps
module tb_cdc_pulse_mc;

   logic       clk_a = 1'b0;
   logic       clk_b = 1'b0;
   logic       rst_n;
   logic [3:0] pulse_a;
   logic [3:0] clr_ovf_a;
   logic [3:0] pulse_b;
   logic [3:0] busy_a;
   logic [3:0] overflow_a;

   realtime half_a = 5.0;
   realtime half_b = 13.5;

   int tests_run    = 0;
   int tests_failed = 0;
   int pulse_cnt [4] = '{default: 0};

   cdc_pulse_mc #(.NCH(4), .SYNC_STAGES(2), .CNT_W(3)) dut (
      .clk_a      (clk_a),
      .clk_b      (clk_b),
      .rst_n      (rst_n),
      .pulse_a    (pulse_a),
      .clr_ovf_a  (clr_ovf_a),
      .pulse_b    (pulse_b),
      .busy_a     (busy_a),
      .overflow_a (overflow_a)
   );

   initial forever #(half_a) clk_a = ~clk_a;

   // Fractional phase offset keeps clk_b edges off clk_a edges for every period used.
   initial begin
      #0.3;
      forever #(half_b) clk_b = ~clk_b;
   end

   always @(negedge clk_b) begin
      for (int i = 0; i < 4; i++) begin
         if (pulse_b[i] === 1'b1) pulse_cnt[i]++;
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_idle(input int ch);
      int k = 0;
      while (busy_a[ch] !== 1'b0 && k < 3000) begin
         @(negedge clk_a);
         k++;
      end
      repeat (4) @(negedge clk_b);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      pulse_a   = '0;
      clr_ovf_a = '0;
      repeat (3) @(negedge clk_a);
      tests_run++;
      if (busy_a !== 4'b0 || overflow_a !== 4'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_a_outputs: busy_a=%b overflow_a=%b, required 0000 0000", busy_a, overflow_a);
      end
      tests_run++;
      if (pulse_b !== 4'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_pulse_b: pulse_b=%b, required 0000", pulse_b);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk_a);
      tests_run++;
      if (busy_a !== 4'b0 || overflow_a !== 4'b0 || pulse_b !== 4'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_release: busy_a=%b overflow_a=%b pulse_b=%b, required all 0", busy_a, overflow_a, pulse_b);
      end
   endtask

   task automatic test_single();
      int base;
      int lat  = 0;
      bit seen = 1'b0;
      base = pulse_cnt[0];
      @(negedge clk_a);
      pulse_a[0] = 1'b1;
      @(posedge clk_a);
      #1;
      pulse_a[0] = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge clk_b);
         lat++;
         #1;
         if (pulse_b[0] === 1'b1) seen = 1'b1;
      end
      tests_run++;
      if (!seen || lat < 3 || lat > 4) begin
         tests_failed++;
         $display("[TB] FAIL single_latency: seen=%0d after %0d clk_b edges, required 3..4", seen, lat);
      end
      tests_run++;
      if (busy_a[0] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL single_busy_in_flight: busy_a[0]=%b, required 1", busy_a[0]);
      end
      wait_idle(0);
      tests_run++;
      if (busy_a[0] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL single_busy_falls: busy_a[0]=%b, required 0", busy_a[0]);
      end
      tests_run++;
      if (pulse_cnt[0] - base != 1) begin
         tests_failed++;
         $display("[TB] FAIL single_count: %0d pulses, required 1", pulse_cnt[0] - base);
      end
      tests_run++;
      if (overflow_a[0] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL single_ovf: overflow_a[0]=%b, required 0", overflow_a[0]);
      end
   endtask

   task automatic test_hold5();
      int base;
      base = pulse_cnt[1];
      @(negedge clk_a);
      pulse_a[1] = 1'b1;
      repeat (5) @(negedge clk_a);
      pulse_a[1] = 1'b0;
      wait_idle(1);
      tests_run++;
      if (busy_a[1] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL hold5_idle: busy_a[1]=%b, required 0", busy_a[1]);
      end
      tests_run++;
      if (pulse_cnt[1] - base != 5) begin
         tests_failed++;
         $display("[TB] FAIL hold5_count: %0d pulses, required 5", pulse_cnt[1] - base);
      end
      tests_run++;
      if (overflow_a[1] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL hold5_ovf: overflow_a[1]=%b, required 0", overflow_a[1]);
      end
   endtask

   // Slow clk_b guarantees no ack returns while the burst is applied.
   task automatic test_overflow();
      int base;
      half_b = 50.0;
      repeat (20) @(negedge clk_a);
      base = pulse_cnt[2];
      @(negedge clk_a);
      pulse_a[2] = 1'b1;
      repeat (12) @(negedge clk_a);
      pulse_a[2] = 1'b0;
      tests_run++;
      if (overflow_a[2] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ovf_set: overflow_a[2]=%b, required 1", overflow_a[2]);
      end
      wait_idle(2);
      tests_run++;
      if (pulse_cnt[2] - base != 8) begin
         tests_failed++;
         $display("[TB] FAIL ovf_count: %0d pulses, required 8", pulse_cnt[2] - base);
      end
      tests_run++;
      if (overflow_a !== 4'b0100) begin
         tests_failed++;
         $display("[TB] FAIL ovf_sticky: overflow_a=%b, required 0100", overflow_a);
      end
      clr_ovf_a[2] = 1'b1;
      @(negedge clk_a);
      clr_ovf_a[2] = 1'b0;
      tests_run++;
      if (overflow_a[2] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ovf_clear: overflow_a[2]=%b, required 0", overflow_a[2]);
      end
   endtask

   task automatic test_set_beats_clear();
      int base;
      base = pulse_cnt[3];
      @(negedge clk_a);
      pulse_a[3] = 1'b1;
      repeat (8) @(negedge clk_a);
      clr_ovf_a[3] = 1'b1;
      @(negedge clk_a);
      pulse_a[3]   = 1'b0;
      clr_ovf_a[3] = 1'b0;
      tests_run++;
      if (overflow_a[3] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL set_beats_clear: overflow_a[3]=%b, required 1", overflow_a[3]);
      end
      wait_idle(3);
      tests_run++;
      if (pulse_cnt[3] - base != 8) begin
         tests_failed++;
         $display("[TB] FAIL set_beats_clear_count: %0d pulses, required 8", pulse_cnt[3] - base);
      end
   endtask

   task automatic test_all_channels();
      int base [4];
      half_a = 20.0;
      half_b = 2.5;
      repeat (4) @(negedge clk_a);
      for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
      pulse_a = 4'b1111;
      @(negedge clk_a);
      pulse_a = 4'b0000;
      for (int i = 0; i < 4; i++) wait_idle(i);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (pulse_cnt[i] - base[i] != 1) begin
            tests_failed++;
            $display("[TB] FAIL all_channels_count[%0d]: %0d pulses, required 1", i, pulse_cnt[i] - base[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int base;
      half_a = 5.0;
      half_b = 50.0;
      repeat (20) @(negedge clk_a);
      base = pulse_cnt[0];
      pulse_a[0] = 1'b1;
      repeat (4) @(negedge clk_a);
      pulse_a[0] = 1'b0;
      rst_n      = 1'b0;
      #1;
      tests_run++;
      if (busy_a !== 4'b0 || overflow_a !== 4'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_async: busy_a=%b overflow_a=%b, required 0000 0000", busy_a, overflow_a);
      end
      repeat (2) @(negedge clk_a);
      rst_n = 1'b1;
      repeat (100) @(negedge clk_a);
      tests_run++;
      if (pulse_cnt[0] != base) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_no_pulse: %0d pulses, required 0", pulse_cnt[0] - base);
      end
      tests_run++;
      if (busy_a !== 4'b0 || overflow_a !== 4'b0 || pulse_b !== 4'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_outputs: busy_a=%b overflow_a=%b pulse_b=%b, required all 0", busy_a, overflow_a, pulse_b);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold5();
      test_overflow();
      test_set_beats_clear();
      test_all_channels();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
